set_multi_circle: RTL and testbench



---
 rtl/set_multi_circle.sv | 186 ++++++++++++++++++
 tb/tb_set_multi_circle.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/set_multi_circle.sv
`default_nettype none
// ============================================================================
//  Module   : set_multi_circle
//  Purpose  : Scans a GRID x GRID lattice (points 1..GRID on each axis), one
//             point per clock, and counts the points that satisfy a set
//             expression over up to three circles (A=c0, B=c1, C=c2).
//             A job is started by en while idle; all job inputs are latched
//             at that edge, so they may change freely during the scan.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1                 clock, rising edge
//    rst        in   1                 asynchronous reset, active-high
//    en         in   1                 job start, honoured only while idle
//    central    in   NCIRC*2*COORD_W   {x0,y0,x1,y1,...}; circle 0 in MSBs
//    radius     in   NCIRC*COORD_W     {r0,r1,...}; r0 in MSBs
//    mode       in   3                 0 A, 1 A&B, 2 A^B, 3 exactly two of
//                                      {A,B,C}, 4 A|B|C, 5..7 count nothing
//    busy       out  1                 job in progress (scan + done cycle)
//    valid      out  1                 one-cycle pulse, candidate is final
//    candidate  out  CNT_W             running / final point count
// ============================================================================
module set_multi_circle #(
    parameter int COORD_W = 4,
    parameter int GRID    = 8,
    parameter int NCIRC   = 3,
    parameter int CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [NCIRC*2*COORD_W-1:0]   central,
    input  logic [NCIRC*COORD_W-1:0]     radius,
    input  logic [2:0]                   mode,
    output logic                         busy,
    output logic                         valid,
    output logic [CNT_W-1:0]             candidate
);

    // Squares of a COORD_W-bit value need 2*COORD_W bits; their sum needs
    // one more, so the distance test can never wrap.
    localparam int SQ_W  = 2 * COORD_W;
    localparam int SUM_W = 2 * COORD_W + 1;

    localparam logic [COORD_W-1:0] c_grid = COORD_W'(GRID);
    localparam logic [COORD_W-1:0] c_one  = COORD_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                       r_state;
    logic [COORD_W-1:0]           r_x;
    logic [COORD_W-1:0]           r_y;
    logic [NCIRC*2*COORD_W-1:0]   r_central;
    logic [NCIRC*COORD_W-1:0]     r_radius;
    logic [2:0]                   r_mode;

    logic [2:0]                   w_abc;     // {C,B,A} hit flags for (r_x,r_y)
    logic                         w_sel;     // current point satisfies the expression
    logic                         w_last;    // current point is (GRID,GRID)

    // ------------------------------------------------------------------------
    // Per-circle inclusive in-circle test on the latched job parameters.
    // Slots beyond NCIRC do not exist and read as never-hit.
    // ------------------------------------------------------------------------
    generate
        for (genvar j = 0; j < 3; j++) begin : g_circle
            if (j < NCIRC) begin : g_present
                logic [COORD_W-1:0] w_cx;
                logic [COORD_W-1:0] w_cy;
                logic [COORD_W-1:0] w_r;
                logic [COORD_W-1:0] w_dx;
                logic [COORD_W-1:0] w_dy;
                logic [SQ_W-1:0]    w_dx2;
                logic [SQ_W-1:0]    w_dy2;
                logic [SQ_W-1:0]    w_r2;
                logic [SUM_W-1:0]   w_sum;

                assign w_cx = r_central[(NCIRC-j)*2*COORD_W-1 -: COORD_W];
                assign w_cy = r_central[(NCIRC-j)*2*COORD_W-COORD_W-1 -: COORD_W];
                assign w_r  = r_radius[(NCIRC-j)*COORD_W-1 -: COORD_W];

                // Absolute differences computed without signed arithmetic.
                assign w_dx = (r_x >= w_cx) ? (r_x - w_cx) : (w_cx - r_x);
                assign w_dy = (r_y >= w_cy) ? (r_y - w_cy) : (w_cy - r_y);

                assign w_dx2 = SQ_W'(w_dx) * SQ_W'(w_dx);
                assign w_dy2 = SQ_W'(w_dy) * SQ_W'(w_dy);
                assign w_r2  = SQ_W'(w_r)  * SQ_W'(w_r);
                assign w_sum = SUM_W'(w_dx2) + SUM_W'(w_dy2);

                assign w_abc[j] = (w_sum <= SUM_W'(w_r2));
            end else begin : g_absent
                assign w_abc[j] = 1'b0;
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Set expression selected by the latched mode.
    // ------------------------------------------------------------------------
    always_comb begin
        w_sel = 1'b0;
        case (r_mode)
            3'd0:    w_sel = w_abc[0];
            3'd1:    w_sel = w_abc[0] & w_abc[1];
            3'd2:    w_sel = w_abc[0] ^ w_abc[1];
            3'd3:    w_sel = ( w_abc[0] &  w_abc[1] & ~w_abc[2]) |
                             ( w_abc[0] & ~w_abc[1] &  w_abc[2]) |
                             (~w_abc[0] &  w_abc[1] &  w_abc[2]);
            3'd4:    w_sel = |w_abc;
            default: w_sel = 1'b0;
        endcase
    end

    assign w_last = (r_x == c_grid) && (r_y == c_grid);

    // ------------------------------------------------------------------------
    // Job controller. All outputs are registered.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            busy      <= 1'b0;
            valid     <= 1'b0;
            candidate <= '0;
            r_x       <= c_one;
            r_y       <= c_one;
            r_central <= '0;
            r_radius  <= '0;
            r_mode    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    busy  <= 1'b0;
                    valid <= 1'b0;
                    if (en) begin
                        r_central <= central;
                        r_radius  <= radius;
                        r_mode    <= mode;
                        candidate <= '0;
                        r_x       <= c_one;
                        r_y       <= c_one;
                        busy      <= 1'b1;
                        r_state   <= ST_SCAN;
                    end
                end

                ST_SCAN: begin
                    // en is deliberately not looked at here: a job cannot be
                    // restarted once it has been accepted.
                    if (w_sel) begin
                        candidate <= candidate + CNT_W'(1);
                    end
                    if (r_y == c_grid) begin
                        r_y <= c_one;
                        r_x <= r_x + c_one;
                    end else begin
                        r_y <= r_y + c_one;
                    end
                    if (w_last) begin
                        valid   <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    valid   <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    valid   <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_set_multi_circle.sv
`default_nettype none
// ============================================================================
//  Module   : tb_set_multi_circle
//  Purpose  : Self-checking bench for set_multi_circle: directed job table,
//             hand-written corner sequences and random jobs checked against
//             a lattice-counting reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_set_multi_circle;

    localparam int COORD_W = 4;
    localparam int GRID    = 8;
    localparam int NCIRC   = 3;
    localparam int CNT_W   = 8;
    localparam int LAT     = GRID * GRID;

    logic                        clk;
    logic                        rst;
    logic                        en;
    logic [NCIRC*2*COORD_W-1:0]  central;
    logic [NCIRC*COORD_W-1:0]    radius;
    logic [2:0]                  mode;
    logic                        busy;
    logic                        valid;
    logic [CNT_W-1:0]            candidate;

    int errors = 0;
    int checks = 0;

    set_multi_circle #(
        .COORD_W (COORD_W),
        .GRID    (GRID),
        .NCIRC   (NCIRC),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .central   (central),
        .radius    (radius),
        .mode      (mode),
        .busy      (busy),
        .valid     (valid),
        .candidate (candidate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] c;
        logic [11:0] r;
        logic [2:0]  m;
        int          exp;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [23:0] pk_c(input int x0, input int y0, input int x1,
                                         input int y1, input int x2, input int y2);
        pk_c = {x0[3:0], y0[3:0], x1[3:0], y1[3:0], x2[3:0], y2[3:0]};
    endfunction

    function automatic logic [11:0] pk_r(input int r0, input int r1, input int r2);
        pk_r = {r0[3:0], r1[3:0], r2[3:0]};
    endfunction

    // Reference: walk every lattice point, test each circle with plain
    // integer geometry, then apply the set rule by counting members.
    function automatic int ref_count(input logic [23:0] c, input logic [11:0] r,
                                     input logic [2:0] m);
        int total = 0;
        for (int x = 1; x <= GRID; x++) begin
            for (int y = 1; y <= GRID; y++) begin
                bit in_c[3];
                int n = 0;
                for (int j = 0; j < 3; j++) begin
                    int cx = int'(c[23-8*j -: 4]);
                    int cy = int'(c[19-8*j -: 4]);
                    int rr = int'(r[11-4*j -: 4]);
                    in_c[j] = ((x-cx)*(x-cx) + (y-cy)*(y-cy)) <= rr*rr;
                    if (in_c[j]) n++;
                end
                case (m)
                    3'd0: if (in_c[0]) total++;
                    3'd1: if (in_c[0] && in_c[1]) total++;
                    3'd2: if (in_c[0] != in_c[1]) total++;
                    3'd3: if (n == 2) total++;
                    3'd4: if (n >= 1) total++;
                    default: ;
                endcase
            end
        end
        return total;
    endfunction

    // Runs one job from the next falling edge; returns one cycle after the
    // done cycle, i.e. just after busy has fallen.
    task automatic run_job(input logic [23:0] c, input logic [11:0] r,
                           input logic [2:0] m, input int exp,
                           input string name, input bit disturb);
        int  cyc;
        bit  seen;
        @(negedge clk);
        central = c; radius = r; mode = m; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        chk({name, " busy_after_en"}, int'(busy), 1);
        chk({name, " cand_cleared"}, int'(candidate), 0);
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc <= 200) begin
            if (disturb && cyc == 10) begin
                en      = 1'b1;
                central = 24'($urandom);
                radius  = 12'($urandom);
                mode    = 3'($urandom);
            end
            if (disturb && cyc == 13) en = 1'b0;
            @(posedge clk); #1;
            if (valid) seen = 1'b1;
            else       cyc++;
        end
        en = 1'b0;
        chk({name, " latency"}, cyc, LAT);
        chk({name, " count"}, int'(candidate), exp);
        chk({name, " busy_in_done"}, int'(busy), 1);
        @(posedge clk); #1;
        chk({name, " valid_drop"}, int'(valid), 0);
        chk({name, " busy_drop"}, int'(busy), 0);
        chk({name, " hold"}, int'(candidate), exp);
    endtask

    initial begin
        vec_t vt[10];
        int   vcount;
        logic [23:0] rc;
        logic [11:0] rr;
        logic [2:0]  rm;

        vt[0] = '{pk_c(4,4,0,0,0,0),   pk_r(2,0,0),  3'd0, 13};
        vt[1] = '{pk_c(4,4,0,0,0,0),   pk_r(15,0,0), 3'd0, 64};
        vt[2] = '{pk_c(1,1,0,0,0,0),   pk_r(0,0,0),  3'd0, 1};
        vt[3] = '{pk_c(0,0,0,0,0,0),   pk_r(0,0,0),  3'd0, 0};
        vt[4] = '{pk_c(4,4,4,4,0,0),   pk_r(2,2,0),  3'd1, 13};
        vt[5] = '{pk_c(4,4,4,4,0,0),   pk_r(2,2,0),  3'd2, 0};
        vt[6] = '{pk_c(4,4,4,4,15,15), pk_r(2,2,0),  3'd3, 13};
        vt[7] = '{pk_c(4,4,4,4,15,15), pk_r(2,2,0),  3'd4, 13};
        vt[8] = '{pk_c(4,4,4,4,15,15), pk_r(2,2,0),  3'd6, 0};
        vt[9] = '{pk_c(4,4,4,4,4,4),   pk_r(15,15,15), 3'd5, 0};

        rst = 1'b1; en = 1'b0; central = '0; radius = '0; mode = '0;
        #1;
        chk("reset busy", int'(busy), 0);
        chk("reset valid", int'(valid), 0);
        chk("reset cand", int'(candidate), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed table; jobs run back to back, so each new en lands in the
        // cycle after busy falls.
        for (int i = 0; i < 10; i++) begin
            run_job(vt[i].c, vt[i].r, vt[i].m, vt[i].exp, $sformatf("vec%0d", i), 1'b0);
        end

        // en re-pulsed and inputs scrambled mid-job.
        run_job(pk_c(4,4,0,0,0,0), pk_r(2,0,0), 3'd0, 13, "disturb", 1'b1);

        // Reset in the middle of a job.
        @(negedge clk);
        central = pk_c(4,4,0,0,0,0); radius = pk_r(15,0,0); mode = 3'd0; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst busy", int'(busy), 0);
        chk("midrst valid", int'(valid), 0);
        chk("midrst cand", int'(candidate), 0);
        @(negedge clk);
        rst = 1'b0;
        vcount = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (valid || busy) vcount++;
        end
        chk("midrst no_activity", vcount, 0);
        run_job(pk_c(4,4,0,0,0,0), pk_r(2,0,0), 3'd0, 13, "after_rst", 1'b0);

        // Random jobs against the reference model.
        for (int i = 0; i < 12; i++) begin
            rc = {4'($urandom_range(0,15)), 4'($urandom_range(0,15)),
                  4'($urandom_range(0,15)), 4'($urandom_range(0,15)),
                  4'($urandom_range(0,15)), 4'($urandom_range(0,15))};
            rr = {4'($urandom_range(0,6)), 4'($urandom_range(0,6)), 4'($urandom_range(0,6))};
            rm = 3'($urandom_range(0,7));
            run_job(rc, rr, rm, ref_count(rc, rr, rm), $sformatf("rand%0d", i), i[0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
